// File: rtl/pll_rst_pkg.sv
// Shared types and 27 MHz default timing for the PLL power-up/lock supervisor.
package pll_rst_pkg;

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_WAIT   = 3'd1,
        S_STABLE = 3'd2,
        S_RUN    = 3'd3,
        S_FAULT  = 3'd4
    } pll_state_e;

    localparam int unsigned PLL_RST_CYC_DEF      = 27;     // 1 us
    localparam int unsigned LOCK_TIMEOUT_CYC_DEF = 27000;  // 1 ms
    localparam int unsigned LOCK_STABLE_CYC_DEF  = 2700;   // 100 us
    localparam int unsigned MAX_RETRY_DEF        = 3;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchroniser for a single asynchronous level; clears to 0 on reset.
module bit_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_rst_ctrl.sv
// rPLL reset/lock supervisor: pulses pll_reset, waits for stable lock, then releases sys_rst_n.
// Define PLL_RST_CTRL_RETRY_LIMIT_EN to park in S_FAULT after MAX_RETRY lock timeouts.
module pll_rst_ctrl
    import pll_rst_pkg::*;
#(
    parameter int unsigned PLL_RST_CYC      = PLL_RST_CYC_DEF,
    parameter int unsigned LOCK_TIMEOUT_CYC = LOCK_TIMEOUT_CYC_DEF,
    parameter int unsigned LOCK_STABLE_CYC  = LOCK_STABLE_CYC_DEF,
    parameter int unsigned MAX_RETRY        = MAX_RETRY_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       relock_req,
    output logic       pll_reset,
    output logic       sys_rst_n,
    output logic [2:0] state,
    output logic [3:0] retry_cnt,
    output logic       fault
);

    localparam int unsigned TMR_W = $clog2(max3(PLL_RST_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC)) + 1;
    localparam logic [TMR_W-1:0] TMR_RST    = TMR_W'(PLL_RST_CYC);
    localparam logic [TMR_W-1:0] TMR_TO     = TMR_W'(LOCK_TIMEOUT_CYC);
    localparam logic [TMR_W-1:0] TMR_STABLE = TMR_W'(LOCK_STABLE_CYC);
    localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);

`ifdef PLL_RST_CTRL_RETRY_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    pll_state_e       state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [3:0]       retry_q, retry_d;
    logic [3:0]       retry_inc;
    logic             retry_hit;
    logic             pll_reset_q, sys_rst_n_q;
    logic             lock_s;

    bit_sync u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (pll_lock),
        .q_o   (lock_s)
    );

    assign retry_inc = (retry_q == 4'hF) ? 4'hF : retry_q + 4'd1;
    assign retry_hit = ({1'b0, retry_q} + 5'd1) == 5'(MAX_RETRY);

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q - TMR_ONE;
        retry_d = retry_q;
        case (state_q)
            // relock_req is deliberately not looked at here: the pulse must run its full length
            S_RST: begin
                if (tmr_q == TMR_ONE) begin
                    state_d = S_WAIT;
                    tmr_d   = TMR_TO;
                end
            end
            S_WAIT: begin
                if (relock_req) begin
                    state_d = S_RST;
                    tmr_d   = TMR_RST;
                end else if (lock_s) begin
                    state_d = S_STABLE;
                    tmr_d   = TMR_STABLE;
                end else if (tmr_q == TMR_ONE) begin
                    retry_d = retry_inc;
                    state_d = (LIMIT_EN && retry_hit) ? S_FAULT : S_RST;
                    tmr_d   = TMR_RST;
                end
            end
            S_STABLE: begin
                if (relock_req) begin
                    state_d = S_RST;
                    tmr_d   = TMR_RST;
                end else if (!lock_s) begin
                    state_d = S_WAIT;
                    tmr_d   = TMR_TO;
                end else if (tmr_q == TMR_ONE) begin
                    state_d = S_RUN;
                    retry_d = 4'd0;
                end
            end
            S_RUN: begin
                tmr_d = tmr_q;
                if (relock_req || !lock_s) begin
                    state_d = S_RST;
                    tmr_d   = TMR_RST;
                end
            end
`ifdef PLL_RST_CTRL_RETRY_LIMIT_EN
            S_FAULT: begin
                tmr_d = tmr_q;
                if (relock_req) begin
                    state_d = S_RST;
                    tmr_d   = TMR_RST;
                    retry_d = 4'd0;
                end
            end
`endif
            default: begin
                state_d = S_RST;
                tmr_d   = TMR_RST;
            end
        endcase
    end

    // Outputs are registered from state_d so they move on the same edge as state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RST;
            tmr_q       <= TMR_RST;
            retry_q     <= 4'd0;
            pll_reset_q <= 1'b1;
            sys_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            retry_q     <= retry_d;
            pll_reset_q <= (state_d == S_RST) || (state_d == S_FAULT);
            sys_rst_n_q <= (state_d == S_RUN);
        end
    end

`ifdef PLL_RST_CTRL_RETRY_LIMIT_EN
    logic fault_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fault_q <= 1'b0;
        else        fault_q <= (state_d == S_FAULT);
    end
    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    assign pll_reset = pll_reset_q;
    assign sys_rst_n = sys_rst_n_q;
    assign state     = state_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// Bench for pll_rst_ctrl: directed timing scenarios plus random lock/relock traffic vs a phase/age model.
module tb_pll_rst_ctrl;

    localparam int P_RST = 4;
    localparam int P_TO  = 50;
    localparam int P_ST  = 10;
    localparam int P_MAX = 3;
`ifdef PLL_RST_CTRL_RETRY_LIMIT_EN
    localparam bit M_LIMIT = 1'b1;
`else
    localparam bit M_LIMIT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_lock = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_reset, sys_rst_n, fault;
    logic [2:0] state;
    logic [3:0] retry_cnt;

    pll_rst_ctrl #(
        .PLL_RST_CYC      (P_RST),
        .LOCK_TIMEOUT_CYC (P_TO),
        .LOCK_STABLE_CYC  (P_ST),
        .MAX_RETRY        (P_MAX)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_lock   (pll_lock),
        .relock_req (relock_req),
        .pll_reset  (pll_reset),
        .sys_rst_n  (sys_rst_n),
        .state      (state),
        .retry_cnt  (retry_cnt),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc, first_rel, pr_cnt;
    bit prev_pr;
    int rises[$];

    // Reference: phase number, cycles spent in it, retry count, and a 2-deep lock delay line.
    int m_ph, m_age, m_retry;
    bit m_s1, m_s2;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_age = 0; m_retry = 0; m_s1 = 0; m_s2 = 0;
    endtask

    task automatic model_step(input bit lk, input bit rq);
        int nph;
        bit ls;
        ls  = m_s2;
        nph = m_ph;
        case (m_ph)
            0: if (m_age + 1 >= P_RST) nph = 1;
            1: begin
                if (rq) nph = 0;
                else if (ls) nph = 2;
                else if (m_age + 1 >= P_TO) begin
                    m_retry = (m_retry >= 15) ? 15 : m_retry + 1;
                    nph = (M_LIMIT && m_retry == P_MAX) ? 4 : 0;
                end
            end
            2: begin
                if (rq) nph = 0;
                else if (!ls) nph = 1;
                else if (m_age + 1 >= P_ST) begin nph = 3; m_retry = 0; end
            end
            3: if (rq || !ls) nph = 0;
            default: if (rq) begin nph = 0; m_retry = 0; end
        endcase
        m_s2 = m_s1;
        m_s1 = lk;
        m_age = (nph != m_ph) ? 0 : m_age + 1;
        m_ph = nph;
    endtask

    // Called at a negedge: check cycle `cyc`, drive its inputs, advance one clock.
    task automatic tick(input bit lk, input bit rq);
        chk("state", int'(state), m_ph);
        chk("pll_reset", int'(pll_reset), int'(m_ph == 0 || m_ph == 4));
        chk("sys_rst_n", int'(sys_rst_n), int'(m_ph == 3));
        chk("retry_cnt", int'(retry_cnt), m_retry);
        chk("fault", int'(fault), int'(m_ph == 4));
        if (sys_rst_n && first_rel < 0) first_rel = cyc;
        if (pll_reset) pr_cnt++;
        if (pll_reset && !prev_pr) rises.push_back(cyc);
        prev_pr = pll_reset;
        pll_lock = lk;
        relock_req = rq;
        @(posedge clk);
        model_step(lk, rq);
        @(negedge clk);
        relock_req = 1'b0;
        cyc++;
    endtask

    // Called at a negedge; reset is asserted mid-cycle to observe its asynchronous effect.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_state", int'(state), 0);
        chk("rst_pll_reset", int'(pll_reset), 1);
        chk("rst_sys_rst_n", int'(sys_rst_n), 0);
        chk("rst_retry", int'(retry_cnt), 0);
        chk("rst_fault", int'(fault), 0);
        model_reset();
        pll_lock = 1'b0;
        relock_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc = 0; first_rel = -1; pr_cnt = 0; prev_pr = 1'b1;
        rises.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int c0, seg;
        bit lk;
        @(negedge clk);

        // Nominal bring-up: lock at cycle 20, release at 33.
        do_reset();
        while (cyc < 45) tick(cyc >= 20, 1'b0);
        chk("nom_release_cyc", first_rel, 33);
        chk("nom_pll_reset_cycles", pr_cnt, 4);
        chk("nom_retry", int'(retry_cnt), 0);

        // Lock loss in S_RUN: sys_rst_n falls three cycles later.
        c0 = cyc;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("loss_still_run", int'(sys_rst_n), 1);
        tick(1'b0, 1'b0);
        chk("loss_sys_rst_n", int'(sys_rst_n), 0);
        chk("loss_pll_reset", int'(pll_reset), 1);
        chk("loss_latency", cyc - c0, 3);
        repeat (30) tick(1'b1, 1'b0);
        chk("loss_rerelease", int'(sys_rst_n), 1);

        // Relock in S_RUN, then a second pulse inside S_RST must not stretch it.
        c0 = cyc;
        tick(1'b1, 1'b1);
        chk("relock_run_state", int'(state), 0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        chk("relock_rst_last", int'(pll_reset), 1);
        tick(1'b1, 1'b0);
        chk("relock_rst_not_ext", int'(pll_reset), 0);
        chk("relock_rst_len", cyc - c0, 5);
        repeat (20) tick(1'b1, 1'b0);

        // Glitchy lock: high 10..14, low 15, high again from 16.
        do_reset();
        while (cyc < 40) begin
            if (cyc == 18) chk("glitch_back_to_wait", int'(state), 1);
            tick((cyc >= 10) && (cyc != 15), 1'b0);
        end
        chk("glitch_release_cyc", first_rel, 29);

        // Asynchronous reset during S_STABLE, then a full repeat of the sequence.
        do_reset();
        while (cyc < 12) tick(cyc >= 5, 1'b0);
        chk("mid_in_stable", int'(state), 2);
        do_reset();
        while (cyc < 40) tick(cyc >= 20, 1'b0);
        chk("mid_repeat_release", first_rel, 33);

        // Lock never arrives: pulse every 54 cycles.
        do_reset();
`ifdef PLL_RST_CTRL_RETRY_LIMIT_EN
        while (cyc < 170) tick(1'b0, 1'b0);
        chk("to_rise0", (rises.size() > 0) ? rises[0] : -1, 54);
        chk("to_rise1", (rises.size() > 1) ? rises[1] : -1, 108);
        chk("to_fault", int'(fault), 1);
        chk("to_fault_pll_reset", int'(pll_reset), 1);
        chk("to_fault_retry", int'(retry_cnt), 3);
        tick(1'b0, 1'b1);
        chk("fault_relock_state", int'(state), 0);
        chk("fault_relock_retry", int'(retry_cnt), 0);
        chk("fault_relock_fault", int'(fault), 0);
        repeat (10) tick(1'b0, 1'b0);
`else
        while (cyc < 900) tick(1'b0, 1'b0);
        chk("to_rise0", (rises.size() > 0) ? rises[0] : -1, 54);
        chk("to_rise1", (rises.size() > 1) ? rises[1] : -1, 108);
        chk("to_retry_sat", int'(retry_cnt), 15);
        chk("to_no_fault", int'(fault), 0);
`endif

        // Random lock segments and sparse relock pulses, with one reset mid-run.
        do_reset();
        seg = 0;
        lk = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (seg == 0) begin
                lk  = ($urandom_range(0, 3) != 0);
                seg = lk ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 70));
            end
            seg--;
            if (i == 700) do_reset();
            tick(lk, $urandom_range(0, 49) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
